// File: rtl/mips_muldiv_32.sv
// Iterative 32x32 multiply/divide unit for the MIPS datapath.
// One shift/add (multiply) or restoring shift/subtract (divide) step per clock.
// Signed operations iterate on magnitudes; the sign is reapplied on the last step.
module mips_muldiv_32 #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] FS_MUL  = 5'h1A,
    parameter logic [4:0] FS_MULU = 5'h1B,
    parameter logic [4:0] FS_DIV  = 5'h1C,
    parameter logic [4:0] FS_DIVU = 5'h1D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             DZ
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   op_div;
    logic                   op_signed;
    logic                   neg_a;      // product / quotient must be negated
    logic                   neg_r;      // remainder must be negated (dividend sign)
    logic [2*WIDTH-1:0]     acc;        // {hi, lo}: product accumulator or {remainder, dividend/quotient}
    logic [WIDTH-1:0]       opb;        // multiplicand or divisor magnitude

    logic                   in_valid;
    logic                   in_div;
    logic                   in_signed;
    logic                   in_sa;
    logic                   in_sb;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         shifted;
    logic [WIDTH:0]         diff;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       rem;
    logic                   ovf;

    // Two's-complement magnitude of a value that may be interpreted as signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Conditional negation used for the final sign correction of a 64-bit result.
    function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign in_valid  = (FS == FS_MUL) || (FS == FS_MULU) || (FS == FS_DIV) || (FS == FS_DIVU);
    assign in_div    = (FS == FS_DIV) || (FS == FS_DIVU);
    assign in_signed = (FS == FS_MUL) || (FS == FS_DIV);
    assign in_sa     = in_signed && S[WIDTH-1];
    assign in_sb     = in_signed && T[WIDTH-1];

    assign busy = (state == CALC);
    assign done = (state == FIN);
    assign C    = 1'b0;

    // One iteration step plus the sign-corrected results of the final step.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, opb};
        acc_step = acc;
        if (op_div) begin
            if (!diff[WIDTH])
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_step = {sum, acc[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
        prod = fix_sign_wide(acc_step, neg_a);
        quo  = mag(acc_step[WIDTH-1:0], neg_a);
        rem  = mag(acc_step[2*WIDTH-1:WIDTH], neg_r);
        // Only |S|=2^31, |T|=1 with a positive quotient sign leaves bit 31 set.
        ovf  = op_signed && !neg_a && acc_step[WIDTH-1];
    end

    // Handshake FSM, iteration registers and result/flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            neg_a     <= 1'b0;
            neg_r     <= 1'b0;
            acc       <= '0;
            opb       <= '0;
            Y_hi      <= '0;
            Y_lo      <= '0;
            V         <= 1'b0;
            N         <= 1'b0;
            Z         <= 1'b0;
            DZ        <= 1'b0;
        end else if (state != CALC && start && in_valid) begin
            op_div    <= in_div;
            op_signed <= in_signed;
            neg_a     <= in_sa ^ in_sb;
            neg_r     <= in_sa;
            cnt       <= '0;
            if (in_div && T == '0) begin
                Y_lo  <= '1;
                Y_hi  <= S;
                DZ    <= 1'b1;
                V     <= 1'b0;
                N     <= 1'b0;
                Z     <= 1'b0;
                state <= FIN;
            end else begin
                if (in_div) begin
                    acc <= {{WIDTH{1'b0}}, mag(S, in_sa)};
                    opb <= mag(T, in_sb);
                end else begin
                    acc <= {{WIDTH{1'b0}}, mag(T, in_sb)};
                    opb <= mag(S, in_sa);
                end
                state <= CALC;
            end
        end else begin
            case (state)
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        if (op_div) begin
                            Y_hi <= rem;
                            Y_lo <= quo;
                            V    <= ovf;
                            N    <= op_signed && quo[WIDTH-1];
                            Z    <= (quo == '0);
                        end else begin
                            Y_hi <= prod[2*WIDTH-1:WIDTH];
                            Y_lo <= prod[WIDTH-1:0];
                            V    <= 1'b0;
                            N    <= op_signed && prod[2*WIDTH-1];
                            Z    <= (prod == '0);
                        end
                        DZ    <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_32.sv
// Randomized and directed bench for mips_muldiv_32 against a plain-arithmetic model.
module tb_mips_muldiv_32;

    localparam logic [4:0] FS_MUL  = 5'h1A;
    localparam logic [4:0] FS_MULU = 5'h1B;
    localparam logic [4:0] FS_DIV  = 5'h1C;
    localparam logic [4:0] FS_DIVU = 5'h1D;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  FS;
    logic [31:0] S, T;
    logic        busy, done;
    logic [31:0] Y_hi, Y_lo;
    logic        C, V, N, Z, DZ;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        v, n, z, dz;
    } res_t;

    res_t last;

    always #5 clk = ~clk;

    mips_muldiv_32 dut (
        .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T),
        .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo),
        .C(C), .V(V), .N(N), .Z(Z), .DZ(DZ)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        res_t r;
        longint a, b, p, q, m;
        logic [63:0] pu;
        r = '{hi: 32'h0, lo: 32'h0, v: 1'b0, n: 1'b0, z: 1'b0, dz: 1'b0};
        a = $signed(s);
        b = $signed(t);
        if ((fs == FS_DIV || fs == FS_DIVU) && t == 32'h0) begin
            r.lo = 32'hFFFFFFFF;
            r.hi = s;
            r.dz = 1'b1;
        end else if (fs == FS_MUL) begin
            p = a * b;
            r.hi = p[63:32];
            r.lo = p[31:0];
            r.n  = p[63];
            r.z  = (p == 0);
        end else if (fs == FS_MULU) begin
            pu = {32'h0, s} * {32'h0, t};
            r.hi = pu[63:32];
            r.lo = pu[31:0];
            r.z  = (pu == 64'h0);
        end else if (fs == FS_DIV) begin
            q = a / b;
            m = a % b;
            r.lo = q[31:0];
            r.hi = m[31:0];
            r.v  = (s == 32'h80000000 && t == 32'hFFFFFFFF);
            r.n  = r.lo[31];
            r.z  = (r.lo == 32'h0);
        end else begin
            r.lo = s / t;
            r.hi = s % t;
            r.z  = (r.lo == 32'h0);
        end
        return r;
    endfunction

    task automatic issue(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        @(negedge clk);
        FS = fs; S = s; T = t; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        S = $urandom;
        T = $urandom;
        FS = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) bcnt++;
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_hi"}, 64'(Y_hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(Y_lo), 64'(e.lo));
        check({tag, "_flags_cvnzdz"}, 64'({C, V, N, Z, DZ}), 64'({1'b0, e.v, e.n, e.z, e.dz}));
    endtask

    task automatic run_op(input string tag, input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        res_t e;
        int ed, bc;
        bit dz;
        e  = model(fs, s, t);
        dz = (fs == FS_DIV || fs == FS_DIVU) && t == 32'h0;
        issue(fs, s, t);
        wait_done(ed, bc);
        check({tag, "_latency"}, 64'(ed), dz ? 64'd0 : 64'd32);
        check({tag, "_busycycles"}, 64'(bc), dz ? 64'd0 : 64'd32);
        check_res(tag, e);
        last = e;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ed, bc;
        bit seen;
        res_t e;
        logic [4:0] fs_tab [4];
        fs_tab = '{FS_MUL, FS_MULU, FS_DIV, FS_DIVU};

        start = 1'b0; FS = 5'h0; S = 32'h0; T = 32'h0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(Y_hi), 64'd0);
        check("rst_lo", 64'(Y_lo), 64'd0);
        check("rst_flags", 64'({C, V, N, Z, DZ}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mulu_max", FS_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        check("done_width", 64'(done), 64'd0);

        // abort an operation at iteration 10
        issue(FS_DIV, 32'h12345678, 32'h00000013);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(Y_hi), 64'd0);
        check("abort_lo", 64'(Y_lo), 64'd0);
        check("abort_flags", 64'({C, V, N, Z, DZ}), 64'd0);
        seen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        run_op("mulu_2x3", FS_MULU, 32'd2, 32'd3);
        run_op("mul_neg", FS_MUL, 32'hFFFFFFFD, 32'd7);
        run_op("mul_zero", FS_MUL, 32'd0, 32'd5);
        run_op("div_neg", FS_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu_100_7", FS_DIVU, 32'd100, 32'd7);
        run_op("div_ovf", FS_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("divu_dz", FS_DIVU, 32'd100, 32'd0);
        run_op("divu_9_3", FS_DIVU, 32'd9, 32'd3);

        // start during CALC is ignored
        e = model(FS_MULU, 32'd1234, 32'd5678);
        issue(FS_MULU, 32'd1234, 32'd5678);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(FS_DIVU, 32'd77, 32'd5);
        wait_done(ed, bc);
        check("ignore_latency", 64'(ed), 64'd27);
        check_res("ignore", e);

        // back-to-back: new start issued during the FIN cycle
        run_op("b2b_first", FS_MUL, 32'hFFFF0000, 32'h00010001);
        run_op("b2b_second", FS_DIV, 32'd1000, 32'hFFFFFFFD);

        // unsupported function code
        issue(5'h02, 32'd5, 32'd6);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("badfs_no_activity", 64'(seen), 64'd0);
        check_res("badfs_hold", last);

        for (int i = 0; i < 60; i++)
            run_op("rnd", fs_tab[$urandom_range(0, 3)], pick(), pick());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
